noc_page_xbar: RTL and testbench

//  N-port request/response page-rank network; generalises the fixed 4-port NoC to N ports.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/noc_page_xbar_if.sv | 27 ++
 rtl/noc_rr_arb.sv | 38 +++
 rtl/noc_page_xbar.sv | 179 +++++++++++++++++
 tb/tb_noc_page_xbar.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the page-rank crossbar: owner FSM states,
// constant clog2 and the page -> owning-port mapping.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        HOLD  = 2'd2
    } owner_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // The owning port is the top log2(n) bits of the page id.
    function automatic int owner_of(input logic [31:0] page, input int page_w, input int n);
        return int'(page >> (page_w - clog2(n)));
    endfunction

endpackage

// File: rtl/noc_page_xbar_if.sv
// Crossbar bus: per-port request, owner query/reply and response channels.
// master = ports/owners attached to the network, slave = the network itself.
interface noc_page_xbar_if #(
    parameter int N      = 4,
    parameter int PAGE_W = 6,
    parameter int DATA_W = 16
);
    logic [N-1:0]                     req_valid;
    logic [N-1:0][PAGE_W-1:0]         req_page;
    logic [N-1:0]                     req_ready;
    logic [N-1:0]                     query_valid;
    logic [N-1:0][PAGE_W-1:0]         query_page;
    logic [N-1:0]                     reply_valid;
    logic [N-1:0][DATA_W-1:0]         reply_data;
    logic [N-1:0]                     resp_valid;
    logic [N-1:0][DATA_W+PAGE_W-1:0]  resp_data;

    modport master (
        output req_valid, req_page, reply_valid, reply_data,
        input  req_ready, query_valid, query_page, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_page, reply_valid, reply_data,
        output req_ready, query_valid, query_page, resp_valid, resp_data
    );
endinterface

// File: rtl/noc_rr_arb.sv
// N-way round-robin arbiter: search starts at ptr; ptr moves one past the
// winner on every grant and holds when nothing is granted.
module noc_rr_arb
    import noc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         gnt_valid
);
    localparam int PW = clog2(N);

    logic [PW-1:0] ptr, idx, gnt_idx;

    // N is a power of two, so the PW-bit add wraps the search naturally.
    always_comb begin
        grant     = '0;
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (!gnt_valid && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_valid  = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          ptr <= '0;
        else if (gnt_valid) ptr <= gnt_idx + PW'(1);
    end
endmodule

// File: rtl/noc_page_xbar.sv
// N-port page-rank crossbar: per-source request FIFOs, per-owner query FSMs,
// round-robin arbitration on query and response paths. Optional NOC_PERF_EN adds perf_stall.
module noc_page_xbar
    import noc_pkg::*;
#(
    parameter int N      = 4,
    parameter int PAGE_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    noc_page_xbar_if.slave        bus
`ifdef NOC_PERF_EN
    ,
    output logic [N-1:0][15:0]    perf_stall
`endif
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = clog2(N);
    localparam int RW = DATA_W + PAGE_W;

    logic [N-1:0]              ready, push, pop, head_valid;
    logic [N-1:0][PAGE_W-1:0]  head;

    for (genvar s = 0; s < N; s++) begin : g_fifo
        logic [DEPTH-1:0][PAGE_W-1:0] mem;
        logic [AW-1:0]                wr_ptr, rd_ptr;
        logic [CW-1:0]                count;

        // Ready looks only at occupancy, so a full FIFO rejects even on a pop cycle.
        assign ready[s]      = (count != CW'(DEPTH));
        assign push[s]       = bus.req_valid[s] & ready[s];
        assign head_valid[s] = (count != '0);
        assign head[s]       = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push[s]) mem[wr_ptr] <= bus.req_page[s];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[s]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[s])  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    assign bus.req_ready = ready;

    owner_state_t              state [N];
    owner_state_t              state_nxt [N];
    logic [N-1:0][PAGE_W-1:0]  page_q, sel_page;
    logic [N-1:0][DATA_W-1:0]  data_q;
    logic [N-1:0][OW-1:0]      src_q, sel_src;
    logic [N-1:0][N-1:0]       qreq, qgnt, rreq, rgnt;
    logic [N-1:0]              qgnt_v, rgnt_v, released;
    logic [N-1:0][RW-1:0]      resp_sel, resp_d_q;
    logic [N-1:0]              resp_v_q;

    // qreq[d] is indexed by source, rreq[s] by owner.
    for (genvar d = 0; d < N; d++) begin : g_own
        for (genvar s = 0; s < N; s++) begin : g_src
            assign qreq[d][s] = head_valid[s] && (state[d] == IDLE)
                             && (owner_of(32'(head[s]), PAGE_W, N) == d);
            assign rreq[s][d] = (state[d] == HOLD) && (src_q[d] == OW'(s));
        end
    end

    noc_rr_arb #(.N(N)) u_qarb [N-1:0] (
        .clk       (clk),
        .reset     (reset),
        .req       (qreq),
        .grant     (qgnt),
        .gnt_valid (qgnt_v)
    );

    noc_rr_arb #(.N(N)) u_rarb [N-1:0] (
        .clk       (clk),
        .reset     (reset),
        .req       (rreq),
        .grant     (rgnt),
        .gnt_valid (rgnt_v)
    );

    always_comb begin
        pop      = '0;
        released = '0;
        sel_page = '0;
        sel_src  = '0;
        resp_sel = '0;
        for (int d = 0; d < N; d++) begin
            for (int s = 0; s < N; s++) begin
                if (qgnt[d][s]) begin
                    pop[s]      = 1'b1;
                    sel_page[d] = head[s];
                    sel_src[d]  = OW'(s);
                end
                if (rgnt[s][d]) begin
                    released[d] = 1'b1;
                    resp_sel[s] = {data_q[d], page_q[d]};
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < N; d++) begin
            state_nxt[d] = state[d];
            case (state[d])
                IDLE:    if (qgnt_v[d])          state_nxt[d] = QUERY;
                QUERY:   if (bus.reply_valid[d]) state_nxt[d] = HOLD;
                HOLD:    if (released[d])        state_nxt[d] = IDLE;
                default:                         state_nxt[d] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < N; d++) state[d] <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q   <= '0;
            src_q    <= '0;
            data_q   <= '0;
            resp_v_q <= '0;
            resp_d_q <= '0;
        end else begin
            for (int d = 0; d < N; d++) begin
                if (state[d] == IDLE && qgnt_v[d]) begin
                    page_q[d] <= sel_page[d];
                    src_q[d]  <= sel_src[d];
                end
                if (state[d] == QUERY && bus.reply_valid[d]) data_q[d] <= bus.reply_data[d];
            end
            resp_v_q <= rgnt_v;
            for (int s = 0; s < N; s++) resp_d_q[s] <= rgnt_v[s] ? resp_sel[s] : '0;
        end
    end

    always_comb begin
        bus.query_valid = '0;
        bus.query_page  = '0;
        for (int d = 0; d < N; d++) begin
            if (state[d] == QUERY) begin
                bus.query_valid[d] = 1'b1;
                bus.query_page[d]  = page_q[d];
            end
        end
    end

    assign bus.resp_valid = resp_v_q;
    assign bus.resp_data  = resp_d_q;

`ifdef NOC_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall <= '0;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (bus.req_valid[s] && !ready[s] && perf_stall[s] != 16'hFFFF)
                    perf_stall[s] <= perf_stall[s] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_page_xbar.sv
// Directed bench for noc_page_xbar (N=4, PAGE_W=6, DEPTH=4) with a response scoreboard.
// The owner model replies with a page-derived value; NOC_PERF_EN enables the stall-counter step.
module tb_noc_page_xbar;
    localparam int N = 4, PW = 6, DW = 16, DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    noc_page_xbar_if #(.N(N), .PAGE_W(PW), .DATA_W(DW)) bus ();
    logic [N-1:0] auto_en, fire;
`ifdef NOC_PERF_EN
    logic [N-1:0][15:0] perf_stall;
`endif

    noc_page_xbar #(.N(N), .PAGE_W(PW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef NOC_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]    src;
        logic [PW-1:0] page;
    } exp_t;
    exp_t sb[$];

    function automatic logic [DW-1:0] data_of(input logic [PW-1:0] p);
        return 16'hBEEF ^ (16'(p ^ 6'h25) * 16'd257);
    endfunction

    // Owner model: replies in the query cycle when auto_en, or when the bench fires.
    always_comb begin
        bus.reply_valid = '0;
        bus.reply_data  = '0;
        for (int d = 0; d < N; d++) begin
            bus.reply_valid[d] = fire[d] | (auto_en[d] & bus.query_valid[d]);
            bus.reply_data[d]  = data_of(bus.query_page[d]);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int s = 0; s < N; s++) begin
                if (bus.resp_valid[s] === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 128'(bus.resp_valid[s]), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        check("resp_src", 128'(s), 128'(e.src));
                        check("resp_data", 128'(bus.resp_data[s]), 128'({data_of(e.page), e.page}));
                    end
                end
            end
        end
    end

    // Called just after a posedge; holds the request for one cycle.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0][PW-1:0] p,
                               output logic [N-1:0] acc);
        exp_t e;
        bus.req_valid = v;
        bus.req_page  = p;
        @(negedge clk);
        acc = v & bus.req_ready;
        for (int s = 0; s < N; s++) begin
            if (acc[s]) begin
                e.src  = 2'(s);
                e.page = p[s];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = '0;
        fire = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_query(input logic [N-1:0] mask, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((bus.query_valid & mask) == mask) ok = 1'b1;
        end
        check(tag, 128'(ok), 128'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]         acc;
        logic [N-1:0][PW-1:0] pg;
        logic [4:0]           pat;
        logic [N-1:0]         qseen, rseen;
        int                   cnt;

        bus.req_valid = '0;
        bus.req_page  = '0;
        auto_en = '0;
        fire    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_query_valid", 128'(bus.query_valid), 128'(0));
        check("rst_query_page",  128'(bus.query_page),  128'(0));
        check("rst_resp_valid",  128'(bus.resp_valid),  128'(0));
        check("rst_resp_data",   128'(bus.resp_data),   128'(0));
`ifdef NOC_PERF_EN
        check("rst_perf_stall",  128'(perf_stall),      128'(0));
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 128'(bus.req_ready), 128'(4'hF));

        // 1: minimum latency path, src0 -> owner 2
        auto_en = '1;
        @(posedge clk);
        #1;
        pg = '0;
        pg[0] = 6'h25;
        drive_cycle(4'b0001, pg, acc);
        check("t1_accept", 128'(acc), 128'(4'b0001));
        repeat (2) @(negedge clk);
        check("t1_qvalid_t2", 128'(bus.query_valid[2]), 128'(1));
        check("t1_qpage_t2",  128'(bus.query_page[2]),  128'(6'h25));
        @(negedge clk);
        check("t1_no_resp_t3", 128'(bus.resp_valid[0]), 128'(0));
        @(negedge clk);
        check("t1_resp_t4", 128'(bus.resp_valid[0]), 128'(1));
        repeat (3) @(negedge clk);

        // 2: all four sources hit owner 1 together; served 0,1,2,3
        do_reset();
        auto_en = '1;
        pg = {6'h13, 6'h12, 6'h11, 6'h10};
        drive_cycle(4'hF, pg, acc);
        check("t2_accept", 128'(acc), 128'(4'hF));
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("t2_all_served", 128'(sb.size()), 128'(0));
        repeat (8) @(negedge clk);

        // 3: src0 to owners 1,2,3, replies fired together
        do_reset();
        auto_en = '0;
        pg = '0; pg[0] = 6'h11; drive_cycle(4'b0001, pg, acc);
        pg = '0; pg[0] = 6'h22; drive_cycle(4'b0001, pg, acc);
        pg = '0; pg[0] = 6'h33; drive_cycle(4'b0001, pg, acc);
        wait_query(4'b1110, "t3_all_query");
        @(posedge clk);
        #1;
        fire = 4'b1110;
        @(posedge clk);
        #1;
        fire = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat[k] = bus.resp_valid[0];
        end
        check("t3_burst", 128'(pat), 128'(5'b01110));
        check("t3_sb_empty", 128'(sb.size()), 128'(0));

        // 4: fill the FIFO behind a silent owner 3
        do_reset();
        auto_en = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            pg = '0;
            pg[0] = 6'h30 + 6'(i);
            drive_cycle(4'b0001, pg, acc);
            if (acc[0]) cnt++;
        end
        check("t4_accepted", 128'(cnt), 128'(5));
        @(negedge clk);
        check("t4_ready_low", 128'(bus.req_ready[0]), 128'(0));
        @(posedge clk);
        #1;
        fire = 4'b1000;
        @(posedge clk);
        #1;
        fire = '0;
        @(negedge clk);
        check("t4_ready_hold", 128'(bus.req_ready[0]), 128'(0));
        @(negedge clk);
        check("t4_resp",        128'(bus.resp_valid[0]), 128'(1));
        check("t4_ready_pop",   128'(bus.req_ready[0]),  128'(0));
        @(negedge clk);
        check("t4_ready_after", 128'(bus.req_ready[0]),  128'(1));

        // 5: reset while owner 2 is mid-query, with another request queued
        do_reset();
        auto_en = '0;
        pg = '0; pg[1] = 6'h20; drive_cycle(4'b0010, pg, acc);
        pg = '0; pg[1] = 6'h21; drive_cycle(4'b0010, pg, acc);
        wait_query(4'b0100, "t5_in_query");
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_qvalid", 128'(bus.query_valid[2]), 128'(0));
        check("t5_async_qpage",  128'(bus.query_page[2]),  128'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        auto_en = '1;
        qseen = '0;
        rseen = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            qseen |= bus.query_valid;
            rseen |= bus.resp_valid;
        end
        check("t5_no_query", 128'(qseen), 128'(0));
        check("t5_no_resp",  128'(rseen), 128'(0));
        check("t5_ready",    128'(bus.req_ready), 128'(4'hF));

`ifdef NOC_PERF_EN
        // 6: stall counter saturates
        do_reset();
        auto_en = '0;
        bus.req_page = '0;
        bus.req_page[1] = 6'h01;
        bus.req_valid = 4'b0010;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("t6_perf_sat", 128'(perf_stall[1]), 128'(16'hFFFF));
        repeat (20) @(negedge clk);
        check("t6_perf_hold", 128'(perf_stall[1]), 128'(16'hFFFF));
        check("t6_perf_other", 128'(perf_stall[0]), 128'(0));
        bus.req_valid = '0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
